// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - instruction register, field decode and four-cycle issue sequencer
// Optional condition-code evaluation at accept is enabled by defining COND_CHECK_EN.
module instr_decode (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  input  logic [3:0]  flags,
  output logic [2:0]  CTRL_select,
  output logic [4:0]  IR_shamt5,
  output logic [3:0]  IR_rot,
  output logic [1:0]  IR_sh,
  output logic        IR_4th,
  output logic [23:0] IR_imm,
  output logic [3:0]  ra_n,
  output logic [3:0]  ra_d,
  output logic [3:0]  ra_s,
  output logic [3:0]  ra_m,
  output logic        op_valid,
  output logic        illegal,
  output logic        op_skipped
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_SH   = 3'd2,
    S_OUT  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] ir;
  logic        skip, skip_nxt;
  logic        accept;
  logic        sel_legal;
  logic        cond_pass;

  assign accept = instr_valid & instr_ready;

  always_comb begin
    sel_legal = 1'b1;
    case (instr[27:25])
      3'b100, 3'b110, 3'b111: sel_legal = 1'b0;
      default:                sel_legal = 1'b1;
    endcase
  end

`ifdef COND_CHECK_EN
  function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cc)
      4'h0:    cond_ok = z;
      4'h1:    cond_ok = !z;
      4'h2:    cond_ok = c;
      4'h3:    cond_ok = !c;
      4'h4:    cond_ok = n;
      4'h5:    cond_ok = !n;
      4'h6:    cond_ok = v;
      4'h7:    cond_ok = !v;
      4'h8:    cond_ok = c && !z;
      4'h9:    cond_ok = !c || z;
      4'hA:    cond_ok = (n == v);
      4'hB:    cond_ok = (n != v);
      4'hC:    cond_ok = !z && (n == v);
      4'hD:    cond_ok = z || (n != v);
      default: cond_ok = 1'b1;
    endcase
  endfunction

  assign cond_pass = cond_ok(instr[31:28], flags);

  // The condition nibble is consumed at accept time, so the latched copy is never read.
  logic unused_bits;
  assign unused_bits = ^ir[31:28];
`else
  assign cond_pass = 1'b1;

  logic unused_bits;
  assign unused_bits = ^{flags, ir[31:28]};
`endif

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      ir <= 32'd0;
    end else if (accept) begin
      ir <= instr;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state <= S_IDLE;
      skip  <= 1'b0;
    end else begin
      state <= state_nxt;
      skip  <= skip_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    skip_nxt    = skip;
    instr_ready = 1'b0;
    op_valid    = 1'b0;
    illegal     = 1'b0;
    op_skipped  = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        skip_nxt    = 1'b0;
        if (accept) begin
          // Illegal select wins over a failed condition.
          if (!sel_legal) begin
            state_nxt = S_ERR;
          end else begin
            state_nxt = S_RD;
            skip_nxt  = !cond_pass;
          end
        end
      end
      S_RD: begin
        if (skip) begin
          op_skipped = 1'b1;
          skip_nxt   = 1'b0;
          state_nxt  = S_IDLE;
        end else begin
          state_nxt  = S_SH;
        end
      end
      S_SH: begin
        state_nxt = S_OUT;
      end
      S_OUT: begin
        op_valid  = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        illegal   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        skip_nxt  = 1'b0;
      end
    endcase
  end

  assign CTRL_select = ir[27:25];
  assign IR_shamt5   = ir[11:7];
  assign IR_rot      = ir[11:8];
  assign IR_sh       = ir[6:5];
  assign IR_4th      = ir[4];
  assign IR_imm      = ir[23:0];
  assign ra_n        = ir[19:16];
  assign ra_d        = ir[15:12];
  assign ra_s        = ir[11:8];
  assign ra_m        = ir[3:0];

endmodule

// File: tb/tb_instr_decode.sv
// tb/tb_instr_decode.sv - vector table plus scoreboard bench for instr_decode
module tb_instr_decode;

`ifdef COND_CHECK_EN
  localparam bit COND = 1'b1;
`else
  localparam bit COND = 1'b0;
`endif

  localparam logic [1:0] K_OK   = 2'd0;
  localparam logic [1:0] K_ILL  = 2'd1;
  localparam logic [1:0] K_SKIP = 2'd2;
  localparam logic [1:0] K_CF   = COND ? K_SKIP : K_OK;

  logic        CLOCK_50 = 1'b0;
  logic        RESET = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = 32'd0;
  logic [3:0]  flags = 4'd0;
  logic        instr_ready;
  logic [2:0]  CTRL_select;
  logic [4:0]  IR_shamt5;
  logic [3:0]  IR_rot;
  logic [1:0]  IR_sh;
  logic        IR_4th;
  logic [23:0] IR_imm;
  logic [3:0]  ra_n, ra_d, ra_s, ra_m;
  logic        op_valid, illegal, op_skipped;

  instr_decode dut (
    .CLOCK_50   (CLOCK_50),
    .RESET      (RESET),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_ready(instr_ready),
    .flags      (flags),
    .CTRL_select(CTRL_select),
    .IR_shamt5  (IR_shamt5),
    .IR_rot     (IR_rot),
    .IR_sh      (IR_sh),
    .IR_4th     (IR_4th),
    .IR_imm     (IR_imm),
    .ra_n       (ra_n),
    .ra_d       (ra_d),
    .ra_s       (ra_s),
    .ra_m       (ra_m),
    .op_valid   (op_valid),
    .illegal    (illegal),
    .op_skipped (op_skipped)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  flags;
    logic [1:0]  kind;
    logic [2:0]  sel;
    logic [4:0]  shamt5;
    logic [3:0]  rot;
    logic [1:0]  sh;
    logic        b4;
    logic [23:0] imm;
    logic [3:0]  rn, rd, rs, rm;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc;
  } exp_t;

  localparam int NVEC = 17;
  vec_t vec[NVEC];
  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Every completion pulse is matched against the oldest outstanding accept.
  always @(negedge CLOCK_50) begin
    if (op_valid || illegal || op_skipped) begin
      chk("pulse_onehot", $countones({op_valid, illegal, op_skipped}), 1);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got valid=%0b illegal=%0b skipped=%0b required none",
                 op_valid, illegal, op_skipped);
      end else begin
        mon_e = sb.pop_front();
        chk("kind", op_valid ? 0 : (illegal ? 1 : 2), {30'd0, mon_e.v.kind});
        chk("latency", cyc - mon_e.acc, (mon_e.v.kind == K_OK) ? 2 : 0);
        chk("CTRL_select", CTRL_select, mon_e.v.sel);
        chk("IR_shamt5", IR_shamt5, mon_e.v.shamt5);
        chk("IR_rot", IR_rot, mon_e.v.rot);
        chk("IR_sh", IR_sh, mon_e.v.sh);
        chk("IR_4th", IR_4th, mon_e.v.b4);
        chk("IR_imm", IR_imm, mon_e.v.imm);
        chk("ra_n", ra_n, mon_e.v.rn);
        chk("ra_d", ra_d, mon_e.v.rd);
        chk("ra_s", ra_s, mon_e.v.rs);
        chk("ra_m", ra_m, mon_e.v.rm);
      end
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (!instr_ready) chk(name, 0, 1);
  endtask

  task automatic send(input int idx);
    exp_t e;
    int   lows = 0;
    @(negedge CLOCK_50);
    instr_valid = 1'b1;
    instr       = vec[idx].instr;
    flags       = vec[idx].flags;
    wait_ready("ready_timeout");
    e.v   = vec[idx];
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge CLOCK_50);
    instr_valid = 1'b0;
    instr       = $urandom();
    while (!instr_ready && lows < 20) begin
      lows++;
      @(negedge CLOCK_50);
    end
    chk("ready_low_cycles", lows, (vec[idx].kind == K_OK) ? 3 : 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, quiet;
    exp_t e;

    vec[0]  = '{32'hE0821203, 4'h0, K_OK,   3'b000, 5'd4, 4'd2, 2'd0, 1'b0, 24'h821203, 4'd2, 4'd1, 4'd2, 4'd3};
    vec[1]  = '{32'hE3A004FF, 4'h0, K_OK,   3'b001, 5'd9, 4'd4, 2'd3, 1'b1, 24'hA004FF, 4'd0, 4'd0, 4'd4, 4'hF};
    vec[2]  = '{32'hE5910008, 4'h0, K_OK,   3'b010, 5'd0, 4'd0, 2'd0, 1'b0, 24'h910008, 4'd1, 4'd0, 4'd0, 4'd8};
    vec[3]  = '{32'hEA000002, 4'h0, K_OK,   3'b101, 5'd0, 4'd0, 2'd0, 1'b0, 24'h000002, 4'd0, 4'd0, 4'd0, 4'd2};
    vec[4]  = '{32'hE7912103, 4'h0, K_OK,   3'b011, 5'd2, 4'd1, 2'd0, 1'b0, 24'h912103, 4'd1, 4'd2, 4'd1, 4'd3};
    vec[5]  = '{32'hE1A0C0F6, 4'h0, K_OK,   3'b000, 5'd1, 4'd0, 2'd3, 1'b1, 24'hA0C0F6, 4'd0, 4'hC, 4'd0, 4'd6};
    vec[6]  = '{32'hE8000000, 4'h0, K_ILL,  3'b100, 5'd0, 4'd0, 2'd0, 1'b0, 24'h000000, 4'd0, 4'd0, 4'd0, 4'd0};
    vec[7]  = '{32'hEC000000, 4'h0, K_ILL,  3'b110, 5'd0, 4'd0, 2'd0, 1'b0, 24'h000000, 4'd0, 4'd0, 4'd0, 4'd0};
    vec[8]  = '{32'hEE000000, 4'h0, K_ILL,  3'b111, 5'd0, 4'd0, 2'd0, 1'b0, 24'h000000, 4'd0, 4'd0, 4'd0, 4'd0};
    vec[9]  = '{32'h00821203, 4'h0, K_CF,   3'b000, 5'd4, 4'd2, 2'd0, 1'b0, 24'h821203, 4'd2, 4'd1, 4'd2, 4'd3};
    vec[10] = '{32'h00821203, 4'h4, K_OK,   3'b000, 5'd4, 4'd2, 2'd0, 1'b0, 24'h821203, 4'd2, 4'd1, 4'd2, 4'd3};
    vec[11] = '{32'h08000000, 4'h0, K_ILL,  3'b100, 5'd0, 4'd0, 2'd0, 1'b0, 24'h000000, 4'd0, 4'd0, 4'd0, 4'd0};
    vec[12] = '{32'hF0821203, 4'h0, K_OK,   3'b000, 5'd4, 4'd2, 2'd0, 1'b0, 24'h821203, 4'd2, 4'd1, 4'd2, 4'd3};
    vec[13] = '{32'h80821203, 4'h2, K_OK,   3'b000, 5'd4, 4'd2, 2'd0, 1'b0, 24'h821203, 4'd2, 4'd1, 4'd2, 4'd3};
    vec[14] = '{32'h80821203, 4'h6, K_CF,   3'b000, 5'd4, 4'd2, 2'd0, 1'b0, 24'h821203, 4'd2, 4'd1, 4'd2, 4'd3};
    vec[15] = '{32'hB0821203, 4'h8, K_OK,   3'b000, 5'd4, 4'd2, 2'd0, 1'b0, 24'h821203, 4'd2, 4'd1, 4'd2, 4'd3};
    vec[16] = '{32'hB0821203, 4'h9, K_CF,   3'b000, 5'd4, 4'd2, 2'd0, 1'b0, 24'h821203, 4'd2, 4'd1, 4'd2, 4'd3};

    repeat (3) @(negedge CLOCK_50);
    RESET = 1'b0;
    @(negedge CLOCK_50);
    chk("reset_ready", instr_ready, 1);
    chk("reset_pulses", {op_valid, illegal, op_skipped}, 0);
    chk("reset_ir", {CTRL_select, IR_imm, ra_n, ra_d, ra_s, ra_m}, 0);

    for (int i = 0; i < NVEC; i++) send(i);

    // Back-to-back load then branch with a stray word offered mid-sequence.
    @(negedge CLOCK_50);
    instr_valid = 1'b1;
    instr       = vec[2].instr;
    flags       = 4'h0;
    wait_ready("b2b_ready_timeout");
    a1 = cyc + 1;
    e.v = vec[2]; e.acc = a1; sb.push_back(e);
    @(negedge CLOCK_50);
    instr = 32'h12345678;
    wait_ready("b2b_second_timeout");
    instr = vec[3].instr;
    a2 = cyc + 1;
    e.v = vec[3]; e.acc = a2; sb.push_back(e);
    chk("b2b_spacing", a2 - a1, 4);
    @(negedge CLOCK_50);
    instr_valid = 1'b0;
    wait_ready("b2b_drain_timeout");

    // Reset while the instruction sits in SH: no pulse may follow.
    @(negedge CLOCK_50);
    instr_valid = 1'b1;
    instr       = vec[0].instr;
    wait_ready("rst_ready_timeout");
    e.v = vec[0]; e.acc = cyc + 1; sb.push_back(e);
    @(negedge CLOCK_50);
    instr_valid = 1'b0;
    @(negedge CLOCK_50);
    RESET = 1'b1;
    sb.delete();
    @(negedge CLOCK_50);
    RESET = 1'b0;
    chk("midrst_ready", instr_ready, 1);
    chk("midrst_pulses", {op_valid, illegal, op_skipped}, 0);
    chk("midrst_ir", {CTRL_select, IR_shamt5, IR_imm, ra_n, ra_d, ra_s, ra_m}, 0);
    quiet = 0;
    repeat (5) begin
      @(negedge CLOCK_50);
      if (op_valid || illegal || op_skipped) quiet++;
    end
    chk("midrst_no_pulse", quiet, 0);

    send(1);
    repeat (2) @(negedge CLOCK_50);
    chk("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
